// File: rtl/maze_pkg.sv
// Shared constants, cell codes, requester indices and FSM encoding for the maze cell arbiter.
`timescale 1ns/1ps
package maze_pkg;

  localparam int COORD_W    = 6;
  localparam int CELL_W     = 2;
  localparam int NREQ       = 3;
  localparam int MAZE_DIM   = 64;
  localparam int ADDR_W     = 2 * COORD_W;
  localparam int MAZE_CELLS = MAZE_DIM * MAZE_DIM;

  localparam logic [CELL_W-1:0] OUT      = 2'b00;
  localparam logic [CELL_W-1:0] WALL     = 2'b01;
  localparam logic [CELL_W-1:0] FRONTIER = 2'b10;
  localparam logic [CELL_W-1:0] PATH     = 2'b11;

  localparam logic [1:0] REQ_CARVER  = 2'd0;
  localparam logic [1:0] REQ_DISPLAY = 2'd1;
  localparam logic [1:0] REQ_PLAYER  = 2'd2;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  // Row-major cell address: y*64 + x is just the concatenation {y,x}.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] y,
                                                  input logic [COORD_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/maze_cell_arbiter_if.sv
// Requester/response/clear bundle between the three maze requesters and the cell arbiter.
`timescale 1ns/1ps
interface maze_cell_arbiter_if;
  import maze_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_we;
  logic [NREQ*COORD_W-1:0] req_x;
  logic [NREQ*COORD_W-1:0] req_y;
  logic [NREQ*CELL_W-1:0]  req_wdata;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [CELL_W-1:0]       rsp_data;
  logic                    clear_start;
  logic                    clear_busy;
  logic                    clear_done;

  modport master (
    output req_valid, req_we, req_x, req_y, req_wdata, clear_start,
    input  req_ready, rsp_valid, rsp_data, clear_busy, clear_done
  );

  modport slave (
    input  req_valid, req_we, req_x, req_y, req_wdata, clear_start,
    output req_ready, rsp_valid, rsp_data, clear_busy, clear_done
  );

endinterface

// File: rtl/maze_cell_arbiter_clear_engine.sv
// Clear sweep engine: walks all 4096 cells writing OUT, one per cycle, while the arbiter is in CLEAR.
`timescale 1ns/1ps
module maze_clear_engine
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_active,
  output logic              o_busy,
  output logic              o_last,
  output logic              o_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [CELL_W-1:0] o_mem_wdata
);

  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;

  assign o_busy      = i_active;
  assign o_last      = i_active & (r_cnt == {ADDR_W{1'b1}});
  assign o_done      = r_done;
  assign o_mem_en    = i_active;
  assign o_mem_we    = i_active;
  assign o_mem_addr  = r_cnt;
  assign o_mem_wdata = OUT;

  // Sweep counter; parked at 0 outside CLEAR so every sweep starts at cell 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= o_last;
      if (i_active) begin
        r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/maze_cell_arbiter.sv
// Single-port maze cell RAM arbiter for carver, display and player requesters.
// Optional clear sweep is built when MAZE_ARB_CLEAR_EN is defined.
`timescale 1ns/1ps
module maze_cell_arbiter
  import maze_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  maze_cell_arbiter_if.slave arb,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [CELL_W-1:0]  mem_wdata,
  input  logic [CELL_W-1:0]  mem_rdata
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_rr;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [NREQ-1:0]   w_ready;
  logic [1:0]        w_gidx;
  logic              w_gany;
  logic [COORD_W-1:0] w_gx;
  logic [COORD_W-1:0] w_gy;
  logic [CELL_W-1:0] w_gwd;
  logic              w_gwe;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [CELL_W-1:0] w_mem_wdata;
  logic              w_clear_req;
  logic              w_clr_busy;
  logic              w_clr_last;
  logic              w_clr_done;
  logic              w_clr_en;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [CELL_W-1:0] w_clr_wdata;

`ifdef MAZE_ARB_CLEAR_EN
  assign w_clear_req = arb.clear_start;

  maze_clear_engine u_clear (
    .clk         (clk),
    .reset       (reset),
    .i_active    (r_state == ST_CLEAR),
    .o_busy      (w_clr_busy),
    .o_last      (w_clr_last),
    .o_done      (w_clr_done),
    .o_mem_en    (w_clr_en),
    .o_mem_we    (w_clr_we),
    .o_mem_addr  (w_clr_addr),
    .o_mem_wdata (w_clr_wdata)
  );
`else
  logic w_unused_clear_start;
  assign w_unused_clear_start = arb.clear_start;
  assign w_clear_req = 1'b0;
  assign w_clr_busy  = 1'b0;
  assign w_clr_last  = 1'b0;
  assign w_clr_done  = 1'b0;
  assign w_clr_en    = 1'b0;
  assign w_clr_we    = 1'b0;
  assign w_clr_addr  = '0;
  assign w_clr_wdata = OUT;
`endif

  // Grant pick: display strict, carver/player share via the round-robin pointer.
  always_comb begin
    w_gany = 1'b1;
    w_gidx = REQ_DISPLAY;
    if (arb.req_valid[REQ_DISPLAY]) begin
      w_gidx = REQ_DISPLAY;
    end else if (arb.req_valid[REQ_CARVER] && arb.req_valid[REQ_PLAYER]) begin
      w_gidx = r_rr ? REQ_PLAYER : REQ_CARVER;
    end else if (arb.req_valid[REQ_CARVER]) begin
      w_gidx = REQ_CARVER;
    end else if (arb.req_valid[REQ_PLAYER]) begin
      w_gidx = REQ_PLAYER;
    end else begin
      w_gany = 1'b0;
    end
  end

  assign w_gx  = arb.req_x[w_gidx*COORD_W +: COORD_W];
  assign w_gy  = arb.req_y[w_gidx*COORD_W +: COORD_W];
  assign w_gwd = arb.req_wdata[w_gidx*CELL_W +: CELL_W];
  assign w_gwe = (w_gidx == REQ_DISPLAY) ? 1'b0 : arb.req_we[w_gidx];

  // FSM next state and RAM/grant drive.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = OUT;
    case (r_state)
      ST_ARB: begin
        if (w_gany) begin
          w_ready[w_gidx] = 1'b1;
          w_mem_en        = 1'b1;
          w_mem_we        = w_gwe;
          w_mem_addr      = cell_addr(w_gy, w_gx);
          w_mem_wdata     = w_gwd;
        end else begin
          w_ready = '0;
        end
        if (w_clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_CLEAR: begin
        w_mem_en    = w_clr_en;
        w_mem_we    = w_clr_we;
        w_mem_addr  = w_clr_addr;
        w_mem_wdata = w_clr_wdata;
        if (w_clr_last) begin
          w_state_nxt = ST_ARB;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // State, round-robin pointer and one-cycle read response pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ARB;
      r_rr        <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_ready & {NREQ{~w_mem_we}};
      if (w_ready[REQ_CARVER] || w_ready[REQ_PLAYER]) begin
        r_rr <= ~r_rr;
      end else begin
        r_rr <= r_rr;
      end
    end
  end

  assign arb.req_ready  = w_ready;
  assign arb.rsp_valid  = r_rsp_valid;
  assign arb.rsp_data   = (|r_rsp_valid) ? mem_rdata : OUT;
  assign arb.clear_busy = w_clr_busy;
  assign arb.clear_done = w_clr_done;
  assign mem_en         = w_mem_en;
  assign mem_we         = w_mem_we;
  assign mem_addr       = w_mem_addr;
  assign mem_wdata      = w_mem_wdata;

endmodule

// File: tb/tb_maze_cell_arbiter.sv
// Randomized scoreboard bench for maze_cell_arbiter with a behavioural RAM and reference model.
`timescale 1ns/1ps
module tb_maze_cell_arbiter;
  import maze_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  maze_cell_arbiter_if u_if ();
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata = 2'b00;

  maze_cell_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .arb       (u_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Environment RAM: synchronous single port, plus a bench-only preload path.
  logic [1:0]  ram [0:4095];
  logic        pre_we   = 1'b0;
  logic [11:0] pre_addr = 12'd0;
  logic [1:0]  pre_data = 2'b00;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct packed { logic [2:0] v; logic [1:0] d; } exp_t;
  exp_t       exp_q[$];
  logic [1:0] model_mem [0:4095];
  bit         rr_player = 1'b0;
  bit         exp_done  = 1'b0;
  int         checks    = 0;
  int         failures  = 0;
  bit         pend [3];
  bit         pwe  [3];
  int         px   [3];
  int         py   [3];
  logic [1:0] pwd  [3];
  bit         clr_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [2:0] v);
    if (v[1]) return 1;
    if (v[0] && v[2]) return rr_player ? 2 : 0;
    if (v[0]) return 0;
    if (v[2]) return 2;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      u_if.req_valid[i]         = pend[i];
      u_if.req_we[i]            = pwe[i];
      u_if.req_x[i*6 +: 6]      = 6'(px[i]);
      u_if.req_y[i*6 +: 6]      = 6'(py[i]);
      u_if.req_wdata[i*2 +: 2]  = pwd[i];
    end
    u_if.clear_start = clr_start;
  endtask

  task automatic gen(input int pct);
    for (int i = 0; i < 3; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < pct) begin
        pend[i] = 1'b1;
        pwe[i]  = 1'($urandom_range(0, 1));
        px[i]   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
        py[i]   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
        pwd[i]  = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic set_req(input int i, input bit we, input int x, input int y, input logic [1:0] wd);
    pend[i] = 1'b1; pwe[i] = we; px[i] = x; py[i] = y; pwd[i] = wd;
  endtask

  // One ARB-state cycle: check the combinational grant, then update the model at the edge.
  task automatic cycle();
    int       g;
    int       a;
    bit [2:0] eg;
    drive();
    #1;
    g  = pick({pend[2], pend[1], pend[0]});
    eg = (g < 0) ? 3'b000 : 3'(1 << g);
    a  = 0;
    chk("req_ready", 32'(u_if.req_ready), 32'(eg));
    chk("clear_busy", 32'(u_if.clear_busy), 32'd0);
    chk("clear_done", 32'(u_if.clear_done), 32'(exp_done));
    exp_done = 1'b0;
    chk("mem_en", 32'(mem_en), 32'(g >= 0));
    if (g >= 0) begin
      a = py[g] * MAZE_DIM + px[g];
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("mem_we", 32'(mem_we), 32'((g != 1) && pwe[g]));
      if ((g != 1) && pwe[g]) chk("mem_wdata", 32'(mem_wdata), 32'(pwd[g]));
    end
    @(posedge clk);
    if (g >= 0) begin
      if (g != 1) rr_player = !rr_player;
      if ((g != 1) && pwe[g]) model_mem[a] = pwd[g];
      else exp_q.push_back('{v: eg, d: model_mem[a]});
      pend[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  // Reset with a display read presented in the reset cycle: it must not produce a response.
  task automatic do_reset();
    reset = 1'b1;
    pend  = '{default: 1'b0};
    set_req(1, 1'b0, 1, 1, 2'b00);
    clr_start = 1'b0;
    drive();
    @(posedge clk);
    exp_q.delete();
    rr_player = 1'b0;
    pend      = '{default: 1'b0};
    @(negedge clk);
    reset = 1'b0;
    drive();
    #1;
    chk("rst_ready", 32'(u_if.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("rst_busy", 32'(u_if.clear_busy), 32'd0);
    chk("rst_done", 32'(u_if.clear_done), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
  endtask

`ifdef MAZE_ARB_CLEAR_EN
  task automatic do_clear(input int abort_at);
    pend = '{default: 1'b0};
    set_req(0, 1'b0, 7, 9, 2'b00);
    clr_start = 1'b1;
    cycle();
    for (int k = 0; k < 4096; k++) begin
      gen(30);
      clr_start = 1'($urandom_range(0, 1));
      drive();
      #1;
      chk("clr_ready", 32'(u_if.req_ready), 32'd0);
      chk("clr_busy", 32'(u_if.clear_busy), 32'd1);
      chk("clr_mem_en", 32'(mem_en), 32'd1);
      chk("clr_mem_we", 32'(mem_we), 32'd1);
      chk("clr_mem_addr", 32'(mem_addr), 32'(k));
      chk("clr_wdata", 32'(mem_wdata), 32'd0);
      if (k == abort_at) reset = 1'b1;
      @(posedge clk);
      model_mem[k] = 2'b00;
      if (k == abort_at) begin
        exp_q.delete();
        rr_player = 1'b0;
        pend      = '{default: 1'b0};
        clr_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive();
        #1;
        chk("abort_busy", 32'(u_if.clear_busy), 32'd0);
        chk("abort_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        return;
      end
      @(negedge clk);
    end
    clr_start = 1'b0;
    exp_done  = 1'b1;
  endtask
`endif

  // Scoreboard monitor: every expected read must appear exactly one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (u_if.rsp_valid !== 3'b000 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(u_if.rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(u_if.rsp_valid), 32'(e.v));
        chk("rsp_data", 32'(u_if.rsp_data), 32'(e.d));
      end
    end
  end

  initial begin
    pend = '{default: 1'b0};
    pwe  = '{default: 1'b0};
    px   = '{default: 0};
    py   = '{default: 0};
    pwd  = '{default: 2'b00};
    drive();
    @(negedge clk);
    for (int a = 0; a < 4096; a++) begin
      pre_we       = 1'b1;
      pre_addr     = 12'(a);
      pre_data     = (a == 130) ? PATH : 2'($urandom_range(0, 3));
      model_mem[a] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;
    do_reset();

    set_req(0, 1'b0, 2, 2, 2'b00);
    cycle();
    cycle();

    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 3; r++) if (!pend[r]) set_req(r, 1'b0, i, r, 2'b00);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      if (!pend[0]) set_req(0, 1'b0, 10 + i, 1, 2'b00);
      if (!pend[2]) set_req(2, 1'b0, 20 + i, 2, 2'b00);
      cycle();
    end
    pend = '{default: 1'b0};

    set_req(0, 1'b1, 5, 5, PATH);
    cycle();
    set_req(2, 1'b0, 5, 5, 2'b00);
    cycle();
    cycle();

    repeat (1500) begin
      gen(60);
      cycle();
    end

`ifdef MAZE_ARB_CLEAR_EN
    do_clear(-1);
    repeat (200) begin gen(60); cycle(); end
    do_clear(1000);
    repeat (100) begin gen(60); cycle(); end
    do_clear(-1);
    repeat (200) begin gen(60); cycle(); end
`else
    repeat (20) begin
      gen(60);
      clr_start = 1'($urandom_range(0, 1));
      cycle();
    end
    clr_start = 1'b0;
    repeat (200) begin gen(60); cycle(); end
`endif

    do_reset();
    cycle();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
